// File: rtl/mac_job_sequencer.sv
// mac_job_sequencer
//   Drains a small FIFO of (A,B) operand pairs onto an AXI4-Lite master
//   command port. Each job is written as reg1=A, reg2=B, reg0=1 (start).
//   A pending clear request is written as reg0=2, then reg0=0, and is
//   serviced ahead of any queued job.
//
//   Optional feature macro: MAC_SEQ_READBACK_EN
//     defined   : after the start write, reg3 is read back and presented on
//                 res_data with a one-cycle res_valid pulse.
//     undefined : no readback; cmd_rd, res_valid and res_data are tied 0.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   job_valid/job_ready   operand push handshake, job_a / job_b operands
//   clr_req               one-cycle clear request, merged while pending
//   cmd_wr / cmd_rd       one-cycle command triggers to the master
//   cmd_addr / cmd_wdata  register index and write data, held until cmd_done
//   cmd_done / cmd_rdata  master completion pulse and read data
//   res_valid / res_data  accumulator readback
//   busy                  sequencer not idle
//   err                   sticky command timeout flag
//
// State   | meaning
// IDLE    | waiting for a clear request or a queued job
// CLR1    | writing reg0=2 (clear accumulator)
// CLR0    | writing reg0=0 (release clear)
// WR_A    | writing reg1=A
// WR_B    | writing reg2=B
// GO      | writing reg0=1 (start MAC)
// RD_ACC  | reading reg3 (accumulator), readback builds only

module mac_job_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS        = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [DATA_WIDTH-1:0] job_a,
    input  logic [DATA_WIDTH-1:0] job_b,
    input  logic                  clr_req,
    output logic                  cmd_wr,
    output logic                  cmd_rd,
    output logic [ADDRESS-1:0]    cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_done,
    input  logic [DATA_WIDTH-1:0] cmd_rdata,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  busy,
    output logic                  err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR1, S_CLR0, S_WR_A, S_WR_B, S_GO, S_RD_ACC
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_wr_q, cmd_wr_d;
    logic                  cmd_rd_q, cmd_rd_d;
    logic [ADDRESS-1:0]    cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  err_q, err_d;
    logic                  clr_pend_q, clr_pend_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] fifo_a_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_b_q [FIFO_DEPTH];

    logic fifo_empty, fifo_full, push, pop, waiting, done_ok, tmo_hit;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    // A job is launched from IDLE only when no clear is pending.
    assign pop        = (state_q == S_IDLE) && !clr_pend_q && !fifo_empty;
    // When full, a same-cycle pop frees the slot being written.
    assign job_ready  = !fifo_full || pop;
    assign push       = job_valid && job_ready;

    // The pulse cycle itself is not a wait cycle; cmd_done there is ignored.
    assign waiting = (state_q != S_IDLE) && !cmd_wr_q && !cmd_rd_q;
    assign done_ok = waiting && cmd_done;
    assign tmo_hit = waiting && !cmd_done && (tmo_q == TMO_W'(1));

    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= job_a;
            fifo_b_q[wr_ptr_q] <= job_b;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef MAC_SEQ_READBACK_EN
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
`else
    logic unused_rdata;
    assign unused_rdata = ^cmd_rdata;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_wr_d    = 1'b0;
        cmd_rd_d    = 1'b0;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        op_b_d      = op_b_q;
        err_d       = err_q;
        clr_pend_d  = clr_pend_q;
`ifdef MAC_SEQ_READBACK_EN
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (clr_pend_q) begin
                    state_d     = S_CLR1;
                    clr_pend_d  = 1'b0;
                    cmd_wr_d    = 1'b1;
                    cmd_addr_d  = ADDRESS'(0);
                    cmd_wdata_d = DATA_WIDTH'(2);
                end else if (!fifo_empty) begin
                    state_d     = S_WR_A;
                    op_b_d      = fifo_b_q[rd_ptr_q];
                    cmd_wr_d    = 1'b1;
                    cmd_addr_d  = ADDRESS'(1);
                    cmd_wdata_d = fifo_a_q[rd_ptr_q];
                end
            end
            S_CLR1: if (done_ok) begin
                state_d     = S_CLR0;
                cmd_wr_d    = 1'b1;
                cmd_addr_d  = ADDRESS'(0);
                cmd_wdata_d = DATA_WIDTH'(0);
            end
            S_CLR0: if (done_ok) state_d = S_IDLE;
            S_WR_A: if (done_ok) begin
                state_d     = S_WR_B;
                cmd_wr_d    = 1'b1;
                cmd_addr_d  = ADDRESS'(2);
                cmd_wdata_d = op_b_q;
            end
            S_WR_B: if (done_ok) begin
                state_d     = S_GO;
                cmd_wr_d    = 1'b1;
                cmd_addr_d  = ADDRESS'(0);
                cmd_wdata_d = DATA_WIDTH'(1);
            end
            S_GO: if (done_ok) begin
`ifdef MAC_SEQ_READBACK_EN
                state_d     = S_RD_ACC;
                cmd_rd_d    = 1'b1;
                cmd_addr_d  = ADDRESS'(3);
                cmd_wdata_d = '0;
`else
                state_d     = S_IDLE;
`endif
            end
            S_RD_ACC: if (done_ok) begin
                state_d = S_IDLE;
`ifdef MAC_SEQ_READBACK_EN
                res_valid_d = 1'b1;
                res_data_d  = cmd_rdata;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops the in-flight job or clear; queued jobs stay in the FIFO.
        if (tmo_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end

        // Merge after the launch so a request landing on the CLR1 entry is kept.
        if (clr_req) clr_pend_d = 1'b1;

        if (cmd_wr_d || cmd_rd_d)       tmo_d = TMO_W'(TIMEOUT_CYCLES);
        else if (waiting && tmo_q != '0) tmo_d = tmo_q - TMO_W'(1);
        else                             tmo_d = tmo_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            cmd_wr_q    <= 1'b0;
            cmd_rd_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            op_b_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            clr_pend_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef MAC_SEQ_READBACK_EN
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            op_b_q      <= op_b_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            clr_pend_q  <= clr_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifdef MAC_SEQ_READBACK_EN
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
`endif
        end
    end

    assign cmd_wr    = cmd_wr_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
`ifdef MAC_SEQ_READBACK_EN
    assign cmd_rd    = cmd_rd_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
`else
    assign cmd_rd    = 1'b0;
    assign res_valid = 1'b0;
    assign res_data  = '0;
`endif

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Bench for mac_job_sequencer. The expected command stream and readback
// values are built per job from the register-level rules (A/B/start writes,
// clear writes, accumulator = sum of A*B since the last clear). A simple
// peripheral answers every command 8 cycles after its pulse.
module tb_mac_job_sequencer;

    localparam int T = 64;
`ifdef MAC_SEQ_READBACK_EN
    localparam int NJ = 4;
`else
    localparam int NJ = 3;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_a = '0, job_b = '0;
    logic        clr_req = 1'b0;
    logic        cmd_wr, cmd_rd;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        cmd_done = 1'b0;
    logic [31:0] cmd_rdata = '0;
    logic        res_valid;
    logic [31:0] res_data;
    logic        busy, err;

    mac_job_sequencer #(.DATA_WIDTH(32), .ADDRESS(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(T)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .job_valid(job_valid), .job_ready(job_ready),
        .job_a(job_a), .job_b(job_b), .clr_req(clr_req), .cmd_wr(cmd_wr), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_done(cmd_done), .cmd_rdata(cmd_rdata),
        .res_valid(res_valid), .res_data(res_data), .busy(busy), .err(err)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- expectation model ----------------
    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [31:0] exp_res[$];
    logic [31:0] res_log[$];
    logic [31:0] model_acc = '0;

    task automatic exp_cmd(input logic rd, input logic [31:0] addr, input logic [31:0] data);
        cmd_t c;
        c.rd = rd; c.addr = addr; c.data = data;
        exp_q.push_back(c);
    endtask

    task automatic exp_clear();
        exp_cmd(1'b0, 32'd0, 32'd2);
        exp_cmd(1'b0, 32'd0, 32'd0);
        model_acc = '0;
    endtask

    task automatic exp_job(input logic [31:0] a, input logic [31:0] b);
        exp_cmd(1'b0, 32'd1, a);
        exp_cmd(1'b0, 32'd2, b);
        exp_cmd(1'b0, 32'd0, 32'd1);
        model_acc = model_acc + a * b;
`ifdef MAC_SEQ_READBACK_EN
        exp_cmd(1'b1, 32'd3, 32'd0);
        exp_res.push_back(model_acc);
`endif
    endtask

    // ---------------- peripheral on the master side ----------------
    logic        master_en = 1'b1;
    logic [31:0] p_reg [4];
    logic [31:0] p_acc = '0;

    initial begin
        int          cnt;
        logic        rst_seen, p_rd;
        logic [31:0] p_addr, p_data;
        cnt = 0; p_rd = 1'b0; p_addr = '0; p_data = '0;
        for (int i = 0; i < 4; i++) p_reg[i] = '0;
        forever begin
            @(posedge ACLK);
            rst_seen = ARESET;
            #1;
            cmd_done = 1'b0;
            if (rst_seen) begin
                cnt = 0;
                p_acc = '0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        cmd_done = 1'b1;
                        if (p_rd) cmd_rdata = p_acc;
                        else if (p_addr == 32'd0) begin
                            if (p_data == 32'd1) p_acc = p_acc + p_reg[1] * p_reg[2];
                            else if (p_data == 32'd2) p_acc = '0;
                        end else p_reg[p_addr[1:0]] = p_data;
                    end
                end
                if ((cmd_wr || cmd_rd) && master_en) begin
                    cnt = 8;
                    p_rd = cmd_rd;
                    p_addr = cmd_addr;
                    p_data = cmd_wdata;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int          cyc = 0;
    int          pulses = 0;
    int          last_pulse_cyc = 0;
    logic        prev_pulse = 1'b0;
    logic        go_pend = 1'b0;
    logic        go_done_prev = 1'b0;
    logic [31:0] hold_addr = '0, hold_data = '0;

    initial begin
        cmd_t e;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (ARESET) begin
                go_pend = 1'b0;
                go_done_prev = 1'b0;
                prev_pulse = 1'b0;
                continue;
            end
            if (go_done_prev) begin
`ifdef MAC_SEQ_READBACK_EN
                chk1("rd_after_go", cmd_rd, 1'b1);
`else
                chk1("idle_after_go", busy, 1'b0);
`endif
            end
            go_done_prev = 1'b0;
            if (cmd_wr || cmd_rd) begin
                pulses++;
                last_pulse_cyc = cyc;
                chk1("pulse_one_cycle", prev_pulse, 1'b0);
                chk1("wr_rd_exclusive", cmd_wr & cmd_rd, 1'b0);
                if (exp_q.size() == 0) begin
                    chk32("unexpected_cmd_addr", cmd_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk1("cmd_kind_rd", cmd_rd, e.rd);
                    chk32("cmd_addr", cmd_addr, e.addr);
                    if (!e.rd) chk32("cmd_wdata", cmd_wdata, e.data);
                end
                hold_addr = cmd_addr;
                hold_data = cmd_wdata;
                go_pend = cmd_wr && cmd_addr == 32'd0 && cmd_wdata == 32'd1;
            end else if (busy) begin
                chk32("addr_held", cmd_addr, hold_addr);
                chk32("wdata_held", cmd_wdata, hold_data);
            end
            prev_pulse = cmd_wr | cmd_rd;
            if (cmd_done && go_pend && busy) begin
                go_done_prev = 1'b1;
                go_pend = 1'b0;
            end
`ifdef MAC_SEQ_READBACK_EN
            if (res_valid) begin
                res_log.push_back(res_data);
                if (exp_res.size() == 0) chk32("unexpected_res", res_data, 32'hFFFF_FFFF);
                else chk32("res_data", res_data, exp_res.pop_front());
            end
`else
            chk1("cmd_rd_never", cmd_rd, 1'b0);
            chk1("res_valid_never", res_valid, 1'b0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic do_reset();
        tick();
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
        model_acc = '0;
        exp_q.delete();
        exp_res.delete();
        res_log.delete();
    endtask

    task automatic push_job(input logic [31:0] a, input logic [31:0] b);
        logic r;
        bit   ok;
        ok = 1'b0;
        job_valid = 1'b1; job_a = a; job_b = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge ACLK);
            r = job_ready;
            tick();
            if (r) ok = 1'b1;
        end
        job_valid = 1'b0;
        if (!ok) chk1("push_accepted", 1'b0, 1'b1);
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge ACLK);
            #1;
            if (exp_q.size() == 0 && exp_res.size() == 0 && !busy) ok = 1'b1;
        end
        chk1(name, ok, 1'b1);
    endtask

    task automatic wait_pulses(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge ACLK);
            #1;
            if (pulses >= target) ok = 1'b1;
        end
        chk1("pulses_reached", ok, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base;

        // reset values
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #2;
        ARESET = 1'b0;
        @(negedge ACLK);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_job_ready", job_ready, 1'b1);
        chk1("rst_cmd_wr", cmd_wr, 1'b0);
        chk1("rst_cmd_rd", cmd_rd, 1'b0);
        chk1("rst_res_valid", res_valid, 1'b0);

        // clear then three jobs
        exp_clear();
        exp_job(32'd5, 32'd6);
        exp_job(32'd3, 32'd4);
        exp_job(32'd2, 32'd10);
        tick();
        pulse_clr();
        push_job(32'd5, 32'd6);
        push_job(32'd3, 32'd4);
        push_job(32'd2, 32'd10);
        wait_idle("main_done", 600);
`ifdef MAC_SEQ_READBACK_EN
        chk32("main_res_count", res_log.size(), 32'd3);
        if (res_log.size() == 3) begin
            chk32("main_res0", res_log[0], 32'd30);
            chk32("main_res1", res_log[1], 32'd42);
            chk32("main_res2", res_log[2], 32'd62);
        end
`endif

        // backpressure and timeout, master silent
        do_reset();
        master_en = 1'b0;
        exp_cmd(1'b0, 32'd1, 32'd11);
        exp_cmd(1'b0, 32'd1, 32'd12);
        push_job(32'd11, 32'd1);
        push_job(32'd12, 32'd1);
        push_job(32'd13, 32'd1);
        push_job(32'd14, 32'd1);
        push_job(32'd15, 32'd1);
        @(negedge ACLK);
        #1;
        chk1("full_job_ready", job_ready, 1'b0);
        chk1("full_busy", busy, 1'b1);
        for (int i = 0; i < 200 && !err; i++) begin
            @(negedge ACLK);
            #1;
        end
        chk1("timeout_err", err, 1'b1);
        chk32("timeout_latency", cyc - last_pulse_cyc, T + 1);
        chk1("timeout_idle", busy, 1'b0);
        chk1("timeout_job_ready", job_ready, 1'b1);
        @(negedge ACLK);
        #1;
        chk1("next_job_busy", busy, 1'b1);
        chk1("next_job_ready", job_ready, 1'b1);
        repeat (5) @(negedge ACLK);
        #1;
        chk1("err_sticky", err, 1'b1);
        chk32("timeout_exp_drained", exp_q.size(), 32'd0);
        do_reset();
        master_en = 1'b1;
        @(negedge ACLK);
        #1;
        chk1("err_cleared_by_reset", err, 1'b0);

        // clear request while job 2 is in flight
        exp_job(32'd4, 32'd5);
        exp_job(32'd6, 32'd7);
        exp_clear();
        exp_job(32'd8, 32'd9);
        base = pulses;
        tick();
        push_job(32'd4, 32'd5);
        push_job(32'd6, 32'd7);
        push_job(32'd8, 32'd9);
        wait_pulses(base + NJ + 2);
        pulse_clr();
        wait_idle("clr_mid_done", 600);
`ifdef MAC_SEQ_READBACK_EN
        chk32("clr_res_count", res_log.size(), 32'd3);
        if (res_log.size() == 3) begin
            chk32("clr_res1", res_log[1], 32'd62);
            chk32("clr_res2", res_log[2], 32'd72);
        end
`endif

        // reset during the WR_B wait
        do_reset();
        exp_cmd(1'b0, 32'd1, 32'd9);
        exp_cmd(1'b0, 32'd2, 32'd9);
        base = pulses;
        push_job(32'd9, 32'd9);
        push_job(32'd1, 32'd1);
        wait_pulses(base + 2);
        tick();
        tick();
        tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_job_ready", job_ready, 1'b1);
        chk1("midrst_cmd_wr", cmd_wr, 1'b0);
        chk32("midrst_exp_drained", exp_q.size(), 32'd0);
        base = pulses;
        repeat (15) @(negedge ACLK);
        #1;
        chk32("midrst_fifo_empty", pulses - base, 32'd0);
        model_acc = '0;
        res_log.delete();
        exp_job(32'd7, 32'd3);
        tick();
        push_job(32'd7, 32'd3);
        wait_idle("midrst_job_done", 300);
`ifdef MAC_SEQ_READBACK_EN
        chk32("midrst_res_count", res_log.size(), 32'd1);
        if (res_log.size() == 1) chk32("midrst_res", res_log[0], 32'd21);
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
